// File: rtl/dram_diag_loader.sv
// Dispatch DRAM pair loader: writes one even/odd pair through the diagnostic
// load functions and optionally reads both entries back through the read path.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req_valid/req_ready         pair-write request handshake
//   req_addr                    pair address (DRADR[0:7])
//   req_even, req_odd           entries {A[0:2],B[0:2],PAR,J[7:10]}
//   req_jcom                    common J[1:4]
//   req_verify                  read both entries back after the write
//   ir_load, ir_data            IR load strobe and value {addr, even/odd, 4'b0}
//   dram_latch                  DRAM output latch strobe (verify only)
//   diag_func, diag_load        DIAG[4:6] sub-function and load strobe
//   diag_read                   read-function enable
//   ebus_drive, ebus_out        EBUS drive enable and write data
//   ebus_in                     EBUS read data
//   busy, done, err, err_code   status; err_code held until the next accept
module dram_diag_loader #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned PAIRS  = 256,
    localparam int unsigned AW    = $clog2(PAIRS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [10:0]   req_even,
    input  logic [10:0]   req_odd,
    input  logic [3:0]    req_jcom,
    input  logic          req_verify,
    output logic          ir_load,
    output logic [AW+4:0] ir_data,
    output logic          dram_latch,
    output logic [2:0]    diag_func,
    output logic          diag_load,
    output logic          diag_read,
    output logic          ebus_drive,
    output logic [5:0]    ebus_out,
    input  logic [5:0]    ebus_in,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_LDIR   = 4'd1;
    localparam logic [3:0] S_WSET   = 4'd2;
    localparam logic [3:0] S_WSTB   = 4'd3;
    localparam logic [3:0] S_WHOLD  = 4'd4;
    localparam logic [3:0] S_VLDIR  = 4'd5;
    localparam logic [3:0] S_VLAT   = 4'd6;
    localparam logic [3:0] S_VRD_AB = 4'd7;
    localparam logic [3:0] S_VRD_J  = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    logic [3:0]    state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [2:0]    phase_q, phase_nxt;
    logic          side_q, side_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic [10:0]   even_q, even_nxt, odd_q, odd_nxt;
    logic [3:0]    jcom_q, jcom_nxt;
    logic          verify_q, verify_nxt;
    logic [1:0]    err_code_nxt;

    logic          req_ready_nxt, busy_nxt, done_nxt, err_nxt;
    logic          ir_load_nxt, dram_latch_nxt, diag_load_nxt, diag_read_nxt, ebus_drive_nxt;
    logic [AW+4:0] ir_data_nxt;
    logic [2:0]    diag_func_nxt;
    logic [5:0]    ebus_out_nxt;

    // Entry under readback and its compare results; EBUS[1] is a don't-care in the J read.
    logic [10:0] ent_c;
    logic        last_c, ab_bad_c, j_bad_c;
    assign ent_c    = side_q ? odd_q : even_q;
    assign last_c   = (cnt_q == CW'(SETTLE - 1));
    assign ab_bad_c = (ebus_in != ent_c[10:5]);
    assign j_bad_c  = ((ebus_in & 6'b10_1111) != {ent_c[4], 1'b0, ent_c[3:0]});

    // Next state, then outputs decoded from the next state so every output is a flop.
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        phase_nxt    = phase_q;
        side_nxt     = side_q;
        addr_nxt     = addr_q;
        even_nxt     = even_q;
        odd_nxt      = odd_q;
        jcom_nxt     = jcom_q;
        verify_nxt   = verify_q;
        err_code_nxt = err_code;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt    = S_LDIR;
                    addr_nxt     = req_addr;
                    even_nxt     = req_even;
                    odd_nxt      = req_odd;
                    jcom_nxt     = req_jcom;
                    verify_nxt   = req_verify;
                    side_nxt     = 1'b0;
                    phase_nxt    = 3'd0;
                    cnt_nxt      = '0;
                    err_code_nxt = 2'd0;
                end
            end
            S_LDIR: begin
                state_nxt = S_WSET;
                cnt_nxt   = '0;
                phase_nxt = 3'd0;
            end
            S_WSET: begin
                if (last_c) state_nxt = S_WSTB;
                else        cnt_nxt   = CW'(cnt_q + 1'b1);
            end
            S_WSTB: state_nxt = S_WHOLD;
            S_WHOLD: begin
                if (phase_q == 3'd4) begin
                    state_nxt = verify_q ? S_VLDIR : S_DONE;
                    side_nxt  = 1'b0;
                end else begin
                    state_nxt = S_WSET;
                    phase_nxt = 3'(phase_q + 3'd1);
                    cnt_nxt   = '0;
                end
            end
            S_VLDIR: state_nxt = S_VLAT;
            S_VLAT: begin
                state_nxt = S_VRD_AB;
                cnt_nxt   = '0;
            end
            S_VRD_AB: begin
                if (last_c) begin
                    state_nxt = S_VRD_J;
                    cnt_nxt   = '0;
                    if (ab_bad_c && err_code == 2'd0) err_code_nxt = side_q ? 2'd3 : 2'd1;
                end else begin
                    cnt_nxt = CW'(cnt_q + 1'b1);
                end
            end
            S_VRD_J: begin
                if (last_c) begin
                    if (j_bad_c && err_code == 2'd0) err_code_nxt = side_q ? 2'd3 : 2'd2;
                    if (!side_q) begin
                        side_nxt  = 1'b1;
                        state_nxt = S_VLDIR;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    cnt_nxt = CW'(cnt_q + 1'b1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        req_ready_nxt  = (state_nxt == S_IDLE);
        busy_nxt       = (state_nxt != S_IDLE);
        done_nxt       = 1'b0;
        err_nxt        = 1'b0;
        ir_load_nxt    = 1'b0;
        ir_data_nxt    = '0;
        dram_latch_nxt = 1'b0;
        diag_func_nxt  = 3'd0;
        diag_load_nxt  = 1'b0;
        diag_read_nxt  = 1'b0;
        ebus_drive_nxt = 1'b0;
        ebus_out_nxt   = 6'd0;

        case (state_nxt)
            S_LDIR, S_VLDIR: begin
                ir_load_nxt = 1'b1;
                ir_data_nxt = {addr_nxt, side_nxt, 4'b0000};
            end
            S_WSET, S_WSTB, S_WHOLD: begin
                diag_func_nxt  = phase_nxt;
                diag_load_nxt  = (state_nxt == S_WSTB);
                ebus_drive_nxt = 1'b1;
                case (phase_nxt)
                    3'd0:    ebus_out_nxt = even_nxt[10:5];
                    3'd1:    ebus_out_nxt = odd_nxt[10:5];
                    3'd2:    ebus_out_nxt = {2'b00, jcom_nxt};
                    3'd3:    ebus_out_nxt = {even_nxt[4], 1'b0, even_nxt[3:0]};
                    default: ebus_out_nxt = {odd_nxt[4], 1'b0, odd_nxt[3:0]};
                endcase
            end
            S_VLAT: dram_latch_nxt = 1'b1;
            S_VRD_AB: begin
                diag_read_nxt = 1'b1;
                diag_func_nxt = 3'd3;
            end
            S_VRD_J: begin
                diag_read_nxt = 1'b1;
                diag_func_nxt = 3'd5;
            end
            S_DONE: begin
                done_nxt = 1'b1;
                err_nxt  = (err_code_nxt != 2'd0);
            end
            default: ;
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= 3'd0;
            side_q     <= 1'b0;
            addr_q     <= '0;
            even_q     <= 11'd0;
            odd_q      <= 11'd0;
            jcom_q     <= 4'd0;
            verify_q   <= 1'b0;
            err_code   <= 2'd0;
            req_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ir_load    <= 1'b0;
            ir_data    <= '0;
            dram_latch <= 1'b0;
            diag_func  <= 3'd0;
            diag_load  <= 1'b0;
            diag_read  <= 1'b0;
            ebus_drive <= 1'b0;
            ebus_out   <= 6'd0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            phase_q    <= phase_nxt;
            side_q     <= side_nxt;
            addr_q     <= addr_nxt;
            even_q     <= even_nxt;
            odd_q      <= odd_nxt;
            jcom_q     <= jcom_nxt;
            verify_q   <= verify_nxt;
            err_code   <= err_code_nxt;
            req_ready  <= req_ready_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            ir_load    <= ir_load_nxt;
            ir_data    <= ir_data_nxt;
            dram_latch <= dram_latch_nxt;
            diag_func  <= diag_func_nxt;
            diag_load  <= diag_load_nxt;
            diag_read  <= diag_read_nxt;
            ebus_drive <= ebus_drive_nxt;
            ebus_out   <= ebus_out_nxt;
        end
    end

endmodule

// File: tb/tb_dram_diag_loader.sv
// Testbench for dram_diag_loader: directed and randomized pair writes with
// readback responder, checked against a transaction-level expectation model.
module tb_dram_diag_loader;

    localparam int unsigned S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_verify;
    logic [7:0]  req_addr;
    logic [10:0] req_even, req_odd;
    logic [3:0]  req_jcom;
    logic        ir_load, dram_latch, diag_load, diag_read, ebus_drive, busy, done, err;
    logic [12:0] ir_data;
    logic [2:0]  diag_func;
    logic [5:0]  ebus_out, ebus_in;
    logic [1:0]  err_code;

    // Second instance built with SETTLE=1, shares the request fields.
    logic        v1, rdy1, irl1, lat1, dl1, dr1, ed1, busy1, done1, err1;
    logic [12:0] ird1;
    logic [2:0]  df1;
    logic [5:0]  eo1;
    logic [1:0]  ec1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dram_diag_loader #(.SETTLE(S), .PAIRS(256)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_even(req_even), .req_odd(req_odd), .req_jcom(req_jcom),
        .req_verify(req_verify), .ir_load(ir_load), .ir_data(ir_data), .dram_latch(dram_latch),
        .diag_func(diag_func), .diag_load(diag_load), .diag_read(diag_read),
        .ebus_drive(ebus_drive), .ebus_out(ebus_out), .ebus_in(ebus_in),
        .busy(busy), .done(done), .err(err), .err_code(err_code));

    dram_diag_loader #(.SETTLE(1), .PAIRS(256)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
        .req_addr(req_addr), .req_even(req_even), .req_odd(req_odd), .req_jcom(req_jcom),
        .req_verify(1'b0), .ir_load(irl1), .ir_data(ird1), .dram_latch(lat1),
        .diag_func(df1), .diag_load(dl1), .diag_read(dr1),
        .ebus_drive(ed1), .ebus_out(eo1), .ebus_in(6'd0),
        .busy(busy1), .done(done1), .err(err1), .err_code(ec1));

    function automatic logic [5:0] xy(input logic [10:0] e);
        return e[10:5];
    endfunction

    function automatic logic [5:0] jw(input logic [10:0] e);
        return {e[4], 1'b0, e[3:0]};
    endfunction

    // One pair-write transaction; cm flags corrupt readbacks: 0 evenAB, 1 evenJ, 2 oddAB, 3 oddJ.
    task automatic do_txn(input logic [7:0] a, input logic [10:0] ev, input logic [10:0] od,
                          input logic [3:0] jc, input logic vf, input logic [3:0] cm,
                          input logic hold, output int acc_cyc);
        logic [5:0]  exp_w[5];
        logic [12:0] exp_ir[3];
        logic [1:0]  exp_code;
        logic [2:0]  wf[8];
        logic [5:0]  wd[8];
        logic [12:0] irs[4];
        logic [2:0]  pf;
        logic [5:0]  pd, rv;
        logic [10:0] ent;
        logic        prev_load, err_seen, odd_side;
        logic [1:0]  code_seen;
        int n_exp_ir, lat, nw, nir, nlat, viol, done_k, w;

        exp_w[0] = xy(ev); exp_w[1] = xy(od); exp_w[2] = {2'b00, jc};
        exp_w[3] = jw(ev); exp_w[4] = jw(od);
        exp_ir[0] = {a, 1'b0, 4'b0}; exp_ir[1] = {a, 1'b0, 4'b0}; exp_ir[2] = {a, 1'b1, 4'b0};
        n_exp_ir = vf ? 3 : 1;
        lat = 2 + 5 * (S + 2) + (vf ? 2 * (2 + 2 * S) : 0);
        if (!vf)       exp_code = 2'd0;
        else if (cm[0]) exp_code = 2'd1;
        else if (cm[1]) exp_code = 2'd2;
        else if (cm[2] || cm[3]) exp_code = 2'd3;
        else            exp_code = 2'd0;

        nw = 0; nir = 0; nlat = 0; viol = 0; done_k = 0; prev_load = 1'b0;
        err_seen = 1'b0; code_seen = 2'd0; pf = 3'd0; pd = 6'd0; acc_cyc = 0;

        req_addr = a; req_even = ev; req_odd = od; req_jcom = jc; req_verify = vf;
        req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
            req_valid = 1'b0;
            return;
        end

        for (int k = 1; k <= lat + 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                acc_cyc = cyc;
                if (!hold) req_valid = 1'b0;
            end
            if (busy !== 1'b1 || req_ready !== 1'b0) viol++;
            if (diag_load && diag_read) viol++;
            if (ebus_drive && diag_read) viol++;
            if (prev_load && (diag_func !== pf || ebus_out !== pd || ebus_drive !== 1'b1)) viol++;
            if (diag_load) begin
                if (ebus_drive !== 1'b1) viol++;
                if (nw < 8) begin
                    wf[nw] = diag_func;
                    wd[nw] = ebus_out;
                end
                nw++;
            end
            prev_load = diag_load;
            pf = diag_func;
            pd = ebus_out;
            if (ir_load) begin
                if (nir < 4) irs[nir] = ir_data;
                nir++;
            end
            if (dram_latch) nlat++;
            // Readback responder: model value, optional corruption, random don't-care EBUS[1].
            ebus_in = 6'($urandom);
            if (diag_read) begin
                odd_side = (nir >= 3);
                ent = odd_side ? od : ev;
                if (diag_func == 3'd3) begin
                    rv = xy(ent);
                    if (cm[odd_side ? 2 : 0]) rv = rv ^ 6'h01;
                end else begin
                    rv = jw(ent) | {1'b0, 1'($urandom), 4'b0};
                    if (cm[odd_side ? 3 : 1]) rv = rv ^ 6'h21;
                end
                ebus_in = rv;
            end
            if (done) begin
                done_k = k;
                err_seen = err;
                code_seen = err_code;
                break;
            end
        end

        tests++;
        if (done_k !== lat) begin
            fails++;
            $display("FAIL done_latency: got %0d required %0d (0 = timeout)", done_k, lat);
        end
        tests++;
        if (err_seen !== (exp_code != 2'd0)) begin
            fails++;
            $display("FAIL err_pulse: got %b required %b", err_seen, exp_code != 2'd0);
        end
        tests++;
        if (code_seen !== exp_code) begin
            fails++;
            $display("FAIL err_code: got %0d required %0d", code_seen, exp_code);
        end
        tests++;
        if (nw !== 5) begin
            fails++;
            $display("FAIL load_count: got %0d required 5", nw);
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++;
                if (wf[i] !== 3'(i) || wd[i] !== exp_w[i]) begin
                    fails++;
                    $display("FAIL load_%0d: got func %0d data %02h required func %0d data %02h",
                             i, wf[i], wd[i], i, exp_w[i]);
                end
            end
        end
        tests++;
        if (nir !== n_exp_ir) begin
            fails++;
            $display("FAIL ir_load_count: got %0d required %0d", nir, n_exp_ir);
        end else begin
            for (int i = 0; i < n_exp_ir; i++) begin
                tests++;
                if (irs[i] !== exp_ir[i]) begin
                    fails++;
                    $display("FAIL ir_data_%0d: got %04h required %04h", i, irs[i], exp_ir[i]);
                end
            end
        end
        tests++;
        if (nlat !== (vf ? 2 : 0)) begin
            fails++;
            $display("FAIL dram_latch_count: got %0d required %0d", nlat, vf ? 2 : 0);
        end
        tests++;
        if (viol !== 0) begin
            fails++;
            $display("FAIL protocol: got %0d violations required 0", viol);
        end
        @(negedge clk);
        ebus_in = 6'd0;
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_done_ready: got ready=%b busy=%b required 1 0", req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; v1 = 1'b0; ebus_in = 6'd0;
        req_addr = 8'd0; req_even = 11'd0; req_odd = 11'd0; req_jcom = 4'd0; req_verify = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({req_ready, busy, done, err, err_code, ir_load, diag_load, diag_read, ebus_drive,
             dram_latch, ebus_out, diag_func, ir_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b busy=%b ld=%b drv=%b required all 0",
                     req_ready, busy, diag_load, ebus_drive);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || err_code !== 2'd0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b busy=%b code=%0d required 1 0 0",
                     req_ready, busy, err_code);
        end
    endtask

    task automatic test_directed();
        int a;
        do_txn(8'h2A, 11'h5A3, 11'h1FF, 4'hC, 1'b0, 4'b0000, 1'b0, a);
        do_txn(8'h2A, 11'h5A3, 11'h1FF, 4'hC, 1'b1, 4'b0000, 1'b0, a);
        do_txn(8'h2A, 11'h5A3, 11'h1FF, 4'hC, 1'b1, 4'b1000, 1'b0, a);
        do_txn(8'h13, 11'h2C4, 11'h6B1, 4'h5, 1'b1, 4'b1110, 1'b0, a);
    endtask

    task automatic test_reset_mid();
        int w;
        int a;
        req_addr = 8'h55; req_even = 11'h123; req_odd = 11'h456; req_jcom = 4'h9;
        req_verify = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        w = 0;
        while (!(diag_load === 1'b1 && diag_func === 3'd2) && w < 60) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (w >= 60) begin
            fails++;
            $display("FAIL jcom_strobe_timeout: got no J-common strobe required one");
        end
        rst = 1'b1;
        #1;
        tests++;
        if (diag_load !== 1'b0 || ebus_drive !== 1'b0 || busy !== 1'b0 || ir_load !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got ld=%b drv=%b busy=%b required 0 0 0",
                     diag_load, ebus_drive, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_ready: got %b required 1", req_ready);
        end
        do_txn(8'h55, 11'h123, 11'h456, 4'h9, 1'b1, 4'b0000, 1'b0, a);
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        int lat;
        int bad;
        lat = 2 + 5 * (S + 2);
        do_txn(8'h01, 11'h0F0, 11'h70F, 4'h3, 1'b0, 4'b0000, 1'b1, a0);
        do_txn(8'h02, 11'h3C3, 11'h43C, 4'hA, 1'b0, 4'b0000, 1'b1, a1);
        do_txn(8'h03, 11'h7FF, 11'h000, 4'hF, 1'b0, 4'b0000, 1'b1, a2);
        req_valid = 1'b0;
        tests++;
        if (a1 - a0 !== lat + 1 || a2 - a1 !== lat + 1) begin
            fails++;
            $display("FAIL accept_spacing: got %0d,%0d required %0d", a1 - a0, a2 - a1, lat + 1);
        end
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy || ir_load) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL extra_accept: got %0d busy cycles required 0", bad);
        end
    endtask

    task automatic test_random();
        int a;
        logic vf;
        logic [3:0] cm;
        for (int t = 0; t < 10; t++) begin
            vf = 1'($urandom);
            cm = vf ? 4'($urandom) : 4'b0000;
            do_txn(8'($urandom), 11'($urandom), 11'($urandom), 4'($urandom), vf, cm, 1'b0, a);
        end
    endtask

    task automatic test_settle1();
        int done_k;
        logic [12:0] got_ir;
        logic got_load;
        req_addr = 8'hFF; req_even = 11'h2AA; req_odd = 11'h155; req_jcom = 4'h6;
        v1 = 1'b1;
        done_k = 0; got_ir = '0; got_load = 1'b0;
        tests++;
        if (rdy1 !== 1'b1) begin
            fails++;
            $display("FAIL s1_ready: got %b required 1", rdy1);
        end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin
                v1 = 1'b0;
                got_load = irl1;
                got_ir = ird1;
            end
            if (done1) begin
                done_k = k;
                break;
            end
        end
        tests++;
        if (got_load !== 1'b1 || got_ir !== {8'hFF, 1'b0, 4'b0}) begin
            fails++;
            $display("FAIL s1_ir_data: got load=%b data=%04h required 1 %04h",
                     got_load, got_ir, {8'hFF, 1'b0, 4'b0});
        end
        tests++;
        if (done_k !== 2 + 5 * (1 + 2)) begin
            fails++;
            $display("FAIL s1_done_latency: got %0d required %0d", done_k, 2 + 5 * 3);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_settle1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
